// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Packs field-level RV32I encode requests into 32-bit instruction words and
// emits them, with a word-aligned address, on a registered IMEM write port.
// Requests whose fields cannot be encoded are consumed but produce no word;
// they raise a one-cycle err pulse instead.
//
// Parameters:
//   BASE_ADDR  byte address of the first emitted word
//   DEPTH      IMEM size in words; the word index wraps at DEPTH
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   in_valid / in_ready            encode request handshake
//   in_opcode, in_rd, in_rs1,
//   in_rs2, in_funct3, in_funct7,
//   in_imm                         request fields (imm is signed; byte offset
//                                  for B/J, full value for U)
//   out_valid / out_ready          IMEM write handshake
//   out_addr, out_data             word address and encoded instruction
//   err                            one-cycle pulse for an illegal request
//   emitted                        saturating count of emitted words
//   wrapped                        sticky flag, set when the index wraps
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic        err,
  output logic [15:0] emitted,
  output logic        wrapped
);

  localparam int unsigned      IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_ARI_I  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_ARI_R  = 7'b0110011;

  // Returns {legal, word}. Range checks test that the upper immediate bits
  // are a pure sign extension of the field's top bit.
  function automatic logic [32:0] encode(
    input logic [6:0]  opc,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    logic        legal;
    logic [31:0] word;
    logic        f7_ok;
    f7_ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
    legal = 1'b0;
    word  = 32'h0000_0000;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        legal = (imm[11:0] == 12'h000);
        word  = {imm[31:12], rd, opc};
      end
      OPC_JAL: begin
        legal = (imm[31:20] == {12{imm[20]}}) && (imm[0] == 1'b0);
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
      end
      OPC_JALR, OPC_LOAD: begin
        legal = (imm[31:11] == {21{imm[11]}});
        word  = {imm[11:0], rs1, f3, rd, opc};
      end
      OPC_ARI_I: begin
        // SLLI/SRLI/SRAI carry funct7 and a 5-bit unsigned shift amount
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
          legal = (imm[31:5] == 27'h0) && f7_ok;
          word  = {f7, imm[4:0], rs1, f3, rd, opc};
        end else begin
          legal = (imm[31:11] == {21{imm[11]}});
          word  = {imm[11:0], rs1, f3, rd, opc};
        end
      end
      OPC_STORE: begin
        legal = (imm[31:11] == {21{imm[11]}});
        word  = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      end
      OPC_BRANCH: begin
        legal = (imm[31:12] == {20{imm[12]}}) && (imm[0] == 1'b0);
        word  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
      end
      OPC_ARI_R: begin
        legal = f7_ok;
        word  = {f7, rs2, rs1, f3, rd, opc};
      end
      default: begin
        legal = 1'b0;
        word  = 32'h0000_0000;
      end
    endcase
    return {legal, word};
  endfunction

  // Byte address of a word index.
  function automatic logic [31:0] addr_of(input logic [IDX_W-1:0] idx);
    return BASE_ADDR + (32'(idx) << 2);
  endfunction

  logic [32:0]      enc_s;
  logic             legal_s;
  logic [31:0]      word_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             out_hs_s;
  logic             wrap_s;
  logic [IDX_W-1:0] idx_next_s;

  logic             out_valid_r;
  logic [31:0]      out_data_r;
  logic [31:0]      out_addr_r;
  logic [IDX_W-1:0] idx_r;
  logic             err_r;
  logic [15:0]      emitted_r;
  logic             wrapped_r;

  // Encode the request and work out handshakes and the next word index.
  always_comb begin
    enc_s      = encode(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
    legal_s    = enc_s[32];
    word_s     = enc_s[31:0];
    in_ready_s = !out_valid_r || out_ready;
    accept_s   = in_valid && in_ready_s;
    out_hs_s   = out_valid_r && out_ready;
    wrap_s     = out_hs_s && (idx_r == IDX_LAST);
    if (!out_hs_s) begin
      idx_next_s = idx_r;
    end else if (wrap_s) begin
      idx_next_s = '0;
    end else begin
      idx_next_s = idx_r + IDX_W'(1);
    end
  end

  // Single-entry output register, address index, error pulse and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 32'h0000_0000;
      out_addr_r  <= BASE_ADDR;
      idx_r       <= '0;
      err_r       <= 1'b0;
      emitted_r   <= 16'h0000;
      wrapped_r   <= 1'b0;
    end else begin
      idx_r      <= idx_next_s;
      // Address always follows the index, so it holds while stalled and
      // already points at the next slot when a word loads behind a handshake.
      out_addr_r <= addr_of(idx_next_s);
      err_r      <= accept_s && !legal_s;
      if (accept_s && legal_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= word_s;
      end else if (out_hs_s) begin
        out_valid_r <= 1'b0;
      end
      if (out_hs_s) begin
        if (emitted_r != 16'hFFFF) begin
          emitted_r <= emitted_r + 16'd1;
        end
        if (wrap_s) begin
          wrapped_r <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_addr  = out_addr_r;
  assign err       = err_r;
  assign emitted   = emitted_r;
  assign wrapped   = wrapped_r;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Self-checking bench for instr_encoder (BASE_ADDR = 0x2000, DEPTH = 4).
// A behavioural model computes each instruction word from the field layout
// with shifts and masks, and legality from integer ranges; a compare process
// checks every DUT output against it on each falling edge. Directed steps pin
// the model with hand-computed words, then randomized traffic follows.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

  localparam logic [31:0] TB_BASE  = 32'h0000_2000;
  localparam int          TB_DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic        err;
  logic [15:0] emitted;
  logic        wrapped;

  int n_cmp  = 0;
  int n_fail = 0;

  instr_encoder #(
    .BASE_ADDR(TB_BASE),
    .DEPTH    (TB_DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_opcode(in_opcode),
    .in_rd    (in_rd),
    .in_rs1   (in_rs1),
    .in_rs2   (in_rs2),
    .in_funct3(in_funct3),
    .in_funct7(in_funct7),
    .in_imm   (in_imm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr (out_addr),
    .out_data (out_data),
    .err      (err),
    .emitted  (emitted),
    .wrapped  (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference encoder: word built by placing immediate bits with shifts/masks,
  // legality from plain signed integer ranges. Returns {legal, word}.
  function automatic logic [32:0] ref_encode(
    input logic [6:0]  opc,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    longint      s;
    logic [31:0] w;
    logic [31:0] regs;
    logic [31:0] low;
    bit          ok;
    bit          f7ok;
    bit          even;
    s    = longint'($signed(imm));
    f7ok = (f7 == 7'd0) || (f7 == 7'd32);
    even = ((imm % 32'd2) == 32'd0);
    regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
    low  = (32'(rd) << 7) | 32'(opc);
    ok   = 1'b0;
    w    = 32'd0;
    case (opc)
      7'h37, 7'h17: begin
        ok = ((imm % 32'd4096) == 32'd0);
        w  = (imm & 32'hFFFF_F000) | low;
      end
      7'h6F: begin
        ok = (s >= -64'sd1048576) && (s <= 64'sd1048574) && even;
        w  = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
             (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'hFF) << 12) | low;
      end
      7'h67, 7'h03: begin
        ok = (s >= -64'sd2048) && (s <= 64'sd2047);
        w  = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | low;
      end
      7'h13: begin
        if ((f3 == 3'd1) || (f3 == 3'd5)) begin
          ok = (s >= 64'sd0) && (s <= 64'sd31) && f7ok;
          w  = (32'(f7) << 25) | ((imm & 32'h1F) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | low;
        end else begin
          ok = (s >= -64'sd2048) && (s <= 64'sd2047);
          w  = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | low;
        end
      end
      7'h23: begin
        ok = (s >= -64'sd2048) && (s <= 64'sd2047);
        w  = (((imm >> 5) & 32'h7F) << 25) | regs | ((imm & 32'h1F) << 7) | 32'(opc);
      end
      7'h63: begin
        ok = (s >= -64'sd4096) && (s <= 64'sd4094) && even;
        w  = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'h3F) << 25) | regs |
             (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'd1) << 7) | 32'(opc);
      end
      7'h33: begin
        ok = f7ok;
        w  = (32'(f7) << 25) | regs | low;
      end
      default: begin
        ok = 1'b0;
        w  = 32'd0;
      end
    endcase
    return {ok, w};
  endfunction

  // Model state
  bit          m_init = 1'b0;
  bit          m_valid;
  logic [31:0] m_data;
  int          m_idx;
  bit          m_err;
  int          m_emitted;
  bit          m_wrapped;
  logic [32:0] m_enc;
  bit          m_hs;
  bit          m_acc;

  assign m_enc = ref_encode(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
  assign m_hs  = m_valid && out_ready;
  assign m_acc = in_valid && (!m_valid || out_ready);

  // Model: advance on every rising edge from the inputs presented there.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid   <= 1'b0;
      m_data    <= 32'd0;
      m_idx     <= 0;
      m_err     <= 1'b0;
      m_emitted <= 0;
      m_wrapped <= 1'b0;
      m_init    <= 1'b1;
    end else begin
      if (m_hs) begin
        m_idx <= (m_idx + 1) % TB_DEPTH;
        if (m_idx == TB_DEPTH - 1) m_wrapped <= 1'b1;
        if (m_emitted < 65535) m_emitted <= m_emitted + 1;
      end
      m_err <= m_acc && !m_enc[32];
      if (m_acc && m_enc[32]) begin
        m_valid <= 1'b1;
        m_data  <= m_enc[31:0];
      end else if (m_hs) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Compare process: all outputs against the model on each falling edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      if (m_valid) chk("out_data", out_data, m_data);
      chk("out_addr", out_addr, TB_BASE + 32'(4 * m_idx));
      chk("err", 32'(err), 32'(m_err));
      chk("emitted", 32'(emitted), 32'(m_emitted));
      chk("wrapped", 32'(wrapped), 32'(m_wrapped));
    end
  end

  task automatic req(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] imm);
    in_opcode = opc;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [6:0] opc_tab [0:8];
  int         imm_tab [0:17];

  initial begin
    int k;
    int v;
    opc_tab = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h23, 7'h63, 7'h33};
    imm_tab = '{-2048, 2047, -2049, 2048, -4096, 4094, 4095, 4096, -4097,
                1048574, -1048576, 1048576, -1048578, 0, 31, 32, -1, 7};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_addr", out_addr, TB_BASE);
    chk("rst out_data", out_data, 32'd0);
    chk("rst emitted", 32'(emitted), 32'd0);
    rst_n = 1'b1;

    // Back-to-back directed words, out_ready held high.
    req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);                 // ADDI x1,x0,5
    chk("addi data", out_data, 32'h0050_0093);
    chk("addi addr", out_addr, TB_BASE);
    chk("addi valid", 32'(out_valid), 32'd1);
    req(7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);         // LUI x2
    chk("lui data", out_data, 32'h1234_5137);
    chk("lui addr", out_addr, TB_BASE + 32'd4);
    chk("emitted after addi", 32'(emitted), 32'd1);
    req(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'b0100000, 32'd0);           // SUB x3,x1,x2
    chk("sub data", out_data, 32'h4020_81B3);
    chk("sub addr", out_addr, TB_BASE + 32'd8);
    req(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd12);                // SW x2,12(x1)
    chk("sw data", out_data, 32'h0020_A623);
    chk("sw addr", out_addr, TB_BASE + 32'd12);
    chk("wrapped before", 32'(wrapped), 32'd0);
    req(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);                 // BEQ x1,x2,+8
    chk("beq data", out_data, 32'h0020_8463);
    chk("beq addr wrap", out_addr, TB_BASE);
    chk("wrapped after 4", 32'(wrapped), 32'd1);
    req(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);                 // JAL x0,+8
    chk("jal data", out_data, 32'h0080_006F);
    chk("jal addr", out_addr, TB_BASE + 32'd4);
    req(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7);                 // BEQ imm 7: illegal
    chk("illegal err", 32'(err), 32'd1);
    chk("illegal no valid", 32'(out_valid), 32'd0);
    chk("illegal addr", out_addr, TB_BASE + 32'd8);
    chk("emitted 6", 32'(emitted), 32'd6);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("err one cycle", 32'(err), 32'd0);

    // Stall: one word held while the next request waits.
    out_ready = 1'b0;
    req(7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);         // ADDI x5,x0,-1
    chk("stall word", out_data, 32'hFFF0_0293);
    in_opcode = 7'h37; in_rd = 5'd7; in_imm = 32'hABCD_E000;         // LUI x7 waiting
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall in_ready", 32'(in_ready), 32'd0);
      chk("stall data", out_data, 32'hFFF0_0293);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("drain+accept data", out_data, 32'hABCD_E3B7);
    chk("drain+accept valid", 32'(out_valid), 32'd1);

    // Reset while a word is stalled.
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst out_data", out_data, 32'd0);
    chk("midrst out_addr", out_addr, TB_BASE);
    chk("midrst emitted", 32'(emitted), 32'd0);
    chk("midrst wrapped", 32'(wrapped), 32'd0);
    rst_n = 1'b1;

    // Randomized traffic checked by the model.
    for (int c = 0; c < 4000; c++) begin
      rst_n     = ($urandom_range(0, 599) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      in_valid  = ($urandom_range(0, 9) < 7);
      k = int'($urandom_range(0, 9));
      in_opcode = (k < 9) ? opc_tab[k] : 7'($urandom);
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_funct3 = 3'($urandom);
      k = int'($urandom_range(0, 3));
      in_funct7 = (k < 2) ? 7'd0 : ((k == 2) ? 7'd32 : 7'($urandom));
      k = int'($urandom_range(0, 9));
      if (k < 3) begin
        v = int'($urandom_range(0, 8191)) - 4096;
        in_imm = 32'(v);
      end else if (k == 3) begin
        in_imm = 32'($urandom_range(0, 40));
      end else if (k == 4) begin
        v = int'($urandom_range(0, 32'h3F_FFFF)) - 32'sh20_0000;
        in_imm = 32'(v);
      end else if (k == 5) begin
        in_imm = $urandom;
      end else if (k == 6) begin
        in_imm = $urandom & 32'hFFFF_F000;
      end else begin
        in_imm = 32'(imm_tab[$urandom_range(0, 17)]);
      end
      @(posedge clk);
      #1;
    end

    in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
